// File: rtl/pico_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pico_pkg
//  Description : Shared opcode/state enums and instruction field positions
//                for the picoMips sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pico_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_LI  = 3'd3,
        OP_HEN = 3'd4,
        OP_HEQ = 3'd5,
        OP_J   = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_WB       = 3'd3,
        ST_HS_WAIT  = 3'd4
    } state_e;

    localparam int c_FUNC_LSB = 0;
    localparam int c_FUNC_W   = 3;
    localparam int c_RD_LSB   = 3;
    localparam int c_RD_W     = 4;
    localparam int c_RS_LSB   = 7;
    localparam int c_RS_W     = 4;
    localparam int c_IMM_LSB  = 7;
    localparam int c_IMM_W    = 8;
    localparam int c_JT_LSB   = 3;

endpackage
`default_nettype wire

// File: rtl/pico_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pico_sequencer_if
//  Description : Program-memory fetch and datapath control bundle between
//                the sequencer (master) and memory/register file (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pico_sequencer_if #(
    parameter int PC_W = 4
);
    import pico_pkg::*;

    logic [15:0]            instr;
    logic [PC_W-1:0]        pc;
    logic [c_FUNC_W-1:0]    alu_func;
    logic [c_RD_W-1:0]      rd_addr;
    logic [c_RS_W-1:0]      rs_addr;
    logic [c_IMM_W-1:0]     imm;
    logic                   rd_we;

    modport master (
        input  instr,
        output pc, alu_func, rd_addr, rs_addr, imm, rd_we
    );

    modport slave (
        output instr,
        input  pc, alu_func, rd_addr, rs_addr, imm, rd_we
    );
endinterface
`default_nettype wire

// File: rtl/pico_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : pico_sync2
//  Description : Two-flop synchroniser for raw switch inputs, resets to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pico_sync2 (
    input  wire logic Clock,
    input  wire logic nReset,
    input  wire logic d,
    output logic      q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/pico_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pico_sequencer
//  Description : Multi-cycle control FSM for the picoMips core. Optional
//                single-step mode enabled by defining PICO_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pico_sequencer
    import pico_pkg::*;
#(
    parameter int PC_W       = 4,
    parameter int MUL_CYCLES = 2
) (
    input  wire logic         Clock,
    input  wire logic         nReset,
    input  wire logic         sw_hs,
`ifdef PICO_STEP_EN
    input  wire logic         step_req,
`endif
    pico_sequencer_if.master  bus,
    output logic              halted,
    output logic              illegal
);

    localparam int                 c_CNT_W    = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = (MUL_CYCLES > 0) ? c_CNT_W'(MUL_CYCLES - 1) : '0;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    w_pc_inc;
    logic [15:0]        r_ir;
    logic               w_ir_load;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_illegal;
    logic               w_ill_set;
    logic               w_sw_s;
    logic               w_step_go;
    op_e                w_op;
    logic               w_unused_ir;

    pico_sync2 u_sync_hs (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (sw_hs),
        .q      (w_sw_s)
    );

`ifdef PICO_STEP_EN
    logic w_step_s;
    logic r_step_d;

    pico_sync2 u_sync_step (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (step_req),
        .q      (w_step_s)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) r_step_d <= 1'b0;
        else         r_step_d <= w_step_s;
    end

    // One synchronised rising edge releases exactly one instruction.
    assign w_step_go = w_step_s & ~r_step_d;
`else
    assign w_step_go = 1'b1;
`endif

    assign w_op        = op_e'(r_ir[c_FUNC_LSB +: c_FUNC_W]);
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_unused_ir = r_ir[15];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ir_load) r_ir      <= bus.instr;
            if (w_ill_set) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_ir_load   = 1'b0;
        w_ill_set   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_step_go) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_LI: w_state_nxt = ST_WB;
                    OP_MUL: begin
                        if (MUL_CYCLES > 0) begin
                            w_state_nxt = ST_MUL_WAIT;
                            w_cnt_nxt   = c_CNT_LOAD;
                        end else begin
                            w_state_nxt = ST_WB;
                        end
                    end
                    // Target bits beyond PC_W are dropped by the slice.
                    OP_J: begin
                        w_pc_nxt    = r_ir[c_JT_LSB +: PC_W];
                        w_state_nxt = ST_FETCH;
                    end
                    OP_HEN, OP_HEQ: w_state_nxt = ST_HS_WAIT;
                    default: begin
                        w_pc_nxt    = w_pc_inc;
                        w_ill_set   = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_MUL_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_WB;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_WB: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = ST_FETCH;
            end
            ST_HS_WAIT: begin
                // HEN releases on switch high, HEQ on switch low.
                if (w_sw_s == (w_op == OP_HEN)) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.alu_func = r_ir[c_FUNC_LSB +: c_FUNC_W];
    assign bus.rd_addr  = r_ir[c_RD_LSB   +: c_RD_W];
    assign bus.rs_addr  = r_ir[c_RS_LSB   +: c_RS_W];
    assign bus.imm      = r_ir[c_IMM_LSB  +: c_IMM_W];
    assign bus.rd_we    = (r_state == ST_WB);
    assign halted       = (r_state == ST_HS_WAIT) | ((r_state == ST_FETCH) & ~w_step_go);
    assign illegal      = r_illegal;

endmodule
`default_nettype wire
